capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: capture buffer depth in samples; power of two, minimum 16.
REQ-002 Parameter ADDR_W, default 8: log2(DEPTH).
REQ-003 clk  input  1  sample clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 arm  input  1  single-cycle request to start one acquisition.
REQ-006 abort  input  1  synchronous cancel of any acquisition or readout.
REQ-007 data  input  8  signed ADC sample, one per cycle.
REQ-008 trig  input  1  trigger-detector output, sampled each cycle.
REQ-009 pretrig  input  ADDR_W  number of samples to keep before the trigger sample.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 triggered  output  1  high from trigger acceptance until return to IDLE.
REQ-012 rd_data  output  8  signed readout sample.
REQ-013 rd_valid  output  1  rd_data holds a valid sample.
REQ-014 rd_ready  input  1  consumer accepts rd_data.
REQ-015 rd_last  output  1  current rd_data is the final sample (index DEPTH-1).

Function
REQ-016 States: IDLE, PREFILL, WAIT_TRIG, POST, READ.
REQ-017 IDLE: arm=1 latches pretrig, clamped to DEPTH-1, into pre_q; next state PREFILL, or WAIT_TRIG if pre_q=0.
REQ-018 PREFILL, WAIT_TRIG, POST: every cycle write data to mem[wr_ptr]; increment wr_ptr modulo DEPTH with wrap.
REQ-019 PREFILL: lasts exactly pre_q cycles; trig is ignored, including on the last PREFILL cycle; then WAIT_TRIG.
REQ-020 WAIT_TRIG: trig=1 accepts the trigger, and the sample written that cycle is the trigger sample; triggered rises next cycle; next state POST. The first WAIT_TRIG cycle can accept a trigger.
REQ-021 WAIT_TRIG has no timeout; older samples are overwritten circularly.
REQ-022 POST: writes DEPTH-pre_q-1 further samples, then READ; rd_base = wr_ptr after the final write, i.e. the oldest sample.
REQ-023 The captured record holds DEPTH samples in time order, with the trigger sample at index pre_q.
REQ-024 READ: samples are emitted from index 0 to DEPTH-1 via address rd_base+idx modulo DEPTH; the RAM read has 1-cycle latency.
REQ-025 rd_valid first asserts 1 cycle after READ entry; no bubbles occur while rd_ready stays high, giving one sample per cycle.
REQ-026 While rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
REQ-027 After the transfer with rd_last=1 and rd_ready=1, the next state is IDLE; rd_valid and triggered are low the next cycle.
REQ-028 arm outside IDLE is ignored; trig outside WAIT_TRIG is ignored.
REQ-029 abort=1 in any state gives IDLE next cycle, with rd_valid=0 and triggered=0; abort takes priority over arm, trig and rd_ready.
REQ-030 No memory writes occur in IDLE or READ.

Reset
REQ-031 rst_n=0 immediately sets state IDLE; busy, triggered, rd_valid, rd_last = 0; rd_data = 0; wr_ptr, rd idx, pre_q, post counter = 0.
REQ-032 Memory contents are not reset; reset mid-acquisition or mid-readout discards the record.
REQ-033 Operation resumes on the first clk edge after rst_n deasserts; arm is accepted on that edge.

Structure
REQ-034 Package capture_pkg holds the state encoding, default DEPTH/ADDR_W, and the sample width constant (8).
REQ-035 One sub-module, capture_ram: simple dual-port, one write port, registered read, DEPTH x 8, no reset.
REQ-036 Clamping, counters and pointer arithmetic are done at ADDR_W+1 bits to avoid wrap errors when pre_q=DEPTH-1.

Verification (DEPTH=16, data = cycle count mod 128)
REQ-037 pretrig=4, arm, trig 10 cycles after PREFILL ends, rd_ready=1 -> 16 samples; sample 4 equals the trigger-cycle data; rd_last on sample 15; busy falls after it.
REQ-038 pretrig=0, arm, trig held high -> trigger accepted in the first WAIT_TRIG cycle; trigger sample at index 0.
REQ-039 pretrig=20 -> clamped to 15; trigger sample at index 15; POST writes 0 samples.
REQ-040 trig high throughout PREFILL with pretrig=6 -> ignored; first trig after PREFILL accepted; arm pulses during POST ignored.
REQ-041 rd_ready toggled at random, 50% -> rd_data stable while stalled; sequence identical to the REQ-037 case.
REQ-042 abort during POST, and separately at sample 7 of READ -> IDLE next cycle, rd_valid=0; a fresh arm then produces a correct record. rst_n pulsed low mid-READ -> all outputs 0 immediately.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and defaults for the triggered capture buffer.
package capture_pkg;

  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned SAMPLE_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREFILL   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_READ      = 3'd4
  } state_e;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/capture_if.sv
// Control, sample input and readout handshake of the capture controller.
interface capture_if
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              arm;
  logic              abort;
  sample_t           data;
  logic              trig;
  logic [ADDR_W-1:0] pretrig;
  logic              busy;
  logic              triggered;
  sample_t           rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport slave (
    input  arm, abort, data, trig, pretrig, rd_ready,
    output busy, triggered, rd_data, rd_valid, rd_last
  );

  modport master (
    output arm, abort, data, trig, pretrig, rd_ready,
    input  busy, triggered, rd_data, rd_valid, rd_last
  );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, registered read port, no reset.
module capture_ram
  import capture_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  sample_t       wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output sample_t       rdata_o
);

  sample_t mem_q [DEPTH];
  sample_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_ctrl.sv
// Pre/post-trigger acquisition into a circular buffer, then in-order readout
// with a valid/ready handshake. ADDR_W may exceed log2(DEPTH); pretrig is clamped.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  capture_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0] MAX_PRE = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          triggered_q, triggered_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          busy_q;

  logic [CW-1:0] pre_clamp_c;
  logic [CW-1:0] post_len_c;
  logic [CW-1:0] cnt_inc_c;
  logic          we_c;
  logic          re_c;
  logic [AW-1:0] raddr_c;
  sample_t       ram_rdata;

  assign pre_clamp_c = (CW'(bus.pretrig) > MAX_PRE) ? MAX_PRE : CW'(bus.pretrig);
  assign post_len_c  = MAX_PRE - pre_q;
  assign cnt_inc_c   = cnt_q + CW'(1);
  // No writes happen in READ, so wr_ptr_q is the oldest sample of the record.
  assign raddr_c     = wr_ptr_q + rd_idx_q[AW-1:0];

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    rd_idx_d    = rd_idx_q;
    wr_ptr_d    = wr_ptr_q;
    triggered_d = triggered_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    we_c        = 1'b0;
    re_c        = 1'b0;

    if (bus.abort) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      rd_idx_d    = '0;
      triggered_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            pre_d    = pre_clamp_c;
            cnt_d    = '0;
            rd_idx_d = '0;
            state_d  = (pre_clamp_c == '0) ? S_WAIT_TRIG : S_PREFILL;
          end
        end
        S_PREFILL: begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_inc_c;
          if (cnt_inc_c == pre_q) begin
            cnt_d   = '0;
            state_d = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (bus.trig) begin
            triggered_d = 1'b1;
            cnt_d       = '0;
            state_d     = (post_len_c == '0) ? S_READ : S_POST;
          end
        end
        S_POST: begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_inc_c;
          if (cnt_inc_c == post_len_c) begin
            cnt_d   = '0;
            state_d = S_READ;
          end
        end
        S_READ: begin
          if (rd_valid_q && bus.rd_ready && rd_last_q) begin
            state_d     = S_IDLE;
            triggered_d = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
          end else if ((rd_idx_q != DEPTH_C) && (!rd_valid_q || bus.rd_ready)) begin
            re_c       = 1'b1;
            rd_idx_d   = rd_idx_q + CW'(1);
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_idx_q == MAX_PRE);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      wr_ptr_q    <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data),
    .re_i    (re_c),
    .raddr_i (raddr_c),
    .rdata_o (ram_rdata)
  );

  // RAM output register has no reset; mask it so rd_data reads 0 when not valid.
  assign bus.busy      = busy_q;
  assign bus.triggered = triggered_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl at DEPTH=16; sample data is the cycle count mod 128.
module tb_capture_ctrl;
  import capture_pkg::*;

  localparam int unsigned DEPTH  = 16;
  // One bit wider than log2(DEPTH) so an over-range pretrig can be presented.
  localparam int unsigned ADDR_W = 5;

  logic clk;
  logic rst_n;

  capture_if #(.ADDR_W(ADDR_W)) bus ();

  capture_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  sample_t got [DEPTH];
  int      got_n;
  int      last_idx;
  int      stall_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.data = 8'(cyc % 128);
  endtask

  function automatic sample_t exp_s(input int td, input int pre, input int i);
    return 8'(((td - pre + i) % 128 + 128) % 128);
  endfunction

  // Drains the readout handshake, recording accepted samples and stall instability.
  task automatic collect(input bit rnd, input int max_n);
    bit      prev_stall;
    bit      done;
    sample_t pd;
    logic    pl;
    logic    rr;
    got_n = 0; last_idx = -1; stall_err = 0;
    prev_stall = 1'b0; done = 1'b0; pd = '0; pl = 1'b0;
    for (int i = 0; i < DEPTH; i++) got[i] = '0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (prev_stall && (bus.rd_data !== pd || bus.rd_last !== pl)) stall_err++;
      rr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rd_ready = rr;
      if (bus.rd_valid && rr) begin
        if (got_n < DEPTH) got[got_n] = bus.rd_data;
        if (bus.rd_last && last_idx < 0) last_idx = got_n;
        got_n++;
        if (bus.rd_last || got_n == max_n) done = 1'b1;
      end
      prev_stall = bus.rd_valid && !rr;
      pd = bus.rd_data;
      pl = bus.rd_last;
      tick();
    end
    bus.rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    n_checks++; if (bus.triggered !== 1'b0) begin n_fail++; $display("FAIL reset_triggered: got %0b expected 0", bus.triggered); end
    n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b expected 0", bus.rd_valid); end
    n_checks++; if (bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_last: got %0b expected 0", bus.rd_last); end
    n_checks++; if (bus.rd_data !== 8'sd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", bus.rd_data); end
    // Release reset and arm in the same cycle: the first edge must accept arm.
    rst_n = 1'b1; bus.pretrig = '0; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_arm: busy %0b expected 1", bus.busy); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_abort_idle: busy %0b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    int td;
    bus.pretrig = 5'd4; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (4) tick();
    n_checks++; if (bus.busy !== 1'b1 || bus.triggered !== 1'b0) begin n_fail++; $display("FAIL basic_wait: busy %0b triggered %0b expected 1 0", bus.busy, bus.triggered); end
    repeat (10) tick();
    bus.trig = 1'b1; td = cyc % 128;
    tick();
    bus.trig = 1'b0;
    n_checks++; if (bus.triggered !== 1'b1) begin n_fail++; $display("FAIL basic_triggered: got %0b expected 1", bus.triggered); end
    repeat (11) tick();
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_read_entry: rd_valid %0b busy %0b expected 0 1", bus.rd_valid, bus.busy); end
    tick();
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_s(td, 4, 0)) begin n_fail++; $display("FAIL basic_first_valid: rd_valid %0b data %0d expected 1 %0d", bus.rd_valid, bus.rd_data, exp_s(td, 4, 0)); end
    collect(1'b0, DEPTH);
    n_checks++; if (got_n !== DEPTH) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got_n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (got[i] !== exp_s(td, 4, i)) begin n_fail++; $display("FAIL basic_sample[%0d]: got %0d expected %0d", i, got[i], exp_s(td, 4, i)); end
    end
    n_checks++; if (got[4] !== sample_t'(td)) begin n_fail++; $display("FAIL basic_trigger_idx: got %0d expected %0d", got[4], td); end
    n_checks++; if (last_idx !== DEPTH - 1) begin n_fail++; $display("FAIL basic_last_idx: got %0d expected %0d", last_idx, DEPTH - 1); end
    n_checks++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.triggered !== 1'b0) begin n_fail++; $display("FAIL basic_done: busy %0b rd_valid %0b triggered %0b expected 0 0 0", bus.busy, bus.rd_valid, bus.triggered); end
  endtask

  task automatic test_pre_zero();
    int td;
    bus.pretrig = '0; bus.trig = 1'b1; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0; td = cyc % 128;
    n_checks++; if (bus.triggered !== 1'b0) begin n_fail++; $display("FAIL prezero_early: triggered %0b expected 0", bus.triggered); end
    tick();
    bus.trig = 1'b0;
    n_checks++; if (bus.triggered !== 1'b1) begin n_fail++; $display("FAIL prezero_first_wait: triggered %0b expected 1", bus.triggered); end
    collect(1'b0, DEPTH);
    n_checks++; if (got_n !== DEPTH || last_idx !== DEPTH - 1) begin n_fail++; $display("FAIL prezero_count: got %0d last %0d expected %0d %0d", got_n, last_idx, DEPTH, DEPTH - 1); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (got[i] !== exp_s(td, 0, i)) begin n_fail++; $display("FAIL prezero_sample[%0d]: got %0d expected %0d", i, got[i], exp_s(td, 0, i)); end
    end
  endtask

  task automatic test_clamp();
    int td;
    bus.pretrig = 5'd20; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (14) tick();
    bus.trig = 1'b1;
    tick();
    n_checks++; if (bus.triggered !== 1'b0) begin n_fail++; $display("FAIL clamp_last_prefill_trig: triggered %0b expected 0", bus.triggered); end
    td = cyc % 128;
    tick();
    bus.trig = 1'b0;
    n_checks++; if (bus.triggered !== 1'b1 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_read_entry: triggered %0b rd_valid %0b expected 1 0", bus.triggered, bus.rd_valid); end
    tick();
    n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL clamp_no_post: rd_valid %0b expected 1", bus.rd_valid); end
    collect(1'b0, DEPTH);
    n_checks++; if (got_n !== DEPTH || last_idx !== DEPTH - 1) begin n_fail++; $display("FAIL clamp_count: got %0d last %0d expected %0d %0d", got_n, last_idx, DEPTH, DEPTH - 1); end
    n_checks++; if (got[15] !== sample_t'(td)) begin n_fail++; $display("FAIL clamp_trigger_idx: got %0d expected %0d", got[15], td); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (got[i] !== exp_s(td, 15, i)) begin n_fail++; $display("FAIL clamp_sample[%0d]: got %0d expected %0d", i, got[i], exp_s(td, 15, i)); end
    end
  endtask

  task automatic test_trig_ignored();
    int td;
    bus.pretrig = 5'd6; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0; bus.trig = 1'b1;
    repeat (6) tick();
    bus.trig = 1'b0;
    n_checks++; if (bus.triggered !== 1'b0) begin n_fail++; $display("FAIL ignore_prefill_trig: triggered %0b expected 0", bus.triggered); end
    repeat (2) tick();
    n_checks++; if (bus.triggered !== 1'b0) begin n_fail++; $display("FAIL ignore_wait_low: triggered %0b expected 0", bus.triggered); end
    bus.trig = 1'b1; td = cyc % 128;
    tick();
    bus.trig = 1'b0;
    n_checks++; if (bus.triggered !== 1'b1) begin n_fail++; $display("FAIL ignore_accept: triggered %0b expected 1", bus.triggered); end
    tick();
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    repeat (2) tick();
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    collect(1'b0, DEPTH);
    n_checks++; if (got_n !== DEPTH || last_idx !== DEPTH - 1) begin n_fail++; $display("FAIL ignore_count: got %0d last %0d expected %0d %0d", got_n, last_idx, DEPTH, DEPTH - 1); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (got[i] !== exp_s(td, 6, i)) begin n_fail++; $display("FAIL ignore_sample[%0d]: got %0d expected %0d", i, got[i], exp_s(td, 6, i)); end
    end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_post_arm: busy %0b expected 0", bus.busy); end
  endtask

  task automatic test_stall();
    int td;
    bus.pretrig = 5'd4; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (14) tick();
    bus.trig = 1'b1; td = cyc % 128;
    tick();
    bus.trig = 1'b0;
    collect(1'b1, DEPTH);
    n_checks++; if (got_n !== DEPTH || last_idx !== DEPTH - 1) begin n_fail++; $display("FAIL stall_count: got %0d last %0d expected %0d %0d", got_n, last_idx, DEPTH, DEPTH - 1); end
    n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL stall_stable: %0d unstable cycles, expected 0", stall_err); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (got[i] !== exp_s(td, 4, i)) begin n_fail++; $display("FAIL stall_sample[%0d]: got %0d expected %0d", i, got[i], exp_s(td, 4, i)); end
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_done: busy %0b expected 0", bus.busy); end
  endtask

  task automatic test_abort_post();
    int td;
    bus.pretrig = 5'd4; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (4) tick();
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.triggered !== 1'b1) begin n_fail++; $display("FAIL abortpost_pre: triggered %0b expected 1", bus.triggered); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.triggered !== 1'b0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL abortpost_idle: busy %0b triggered %0b rd_valid %0b expected 0 0 0", bus.busy, bus.triggered, bus.rd_valid); end
    bus.pretrig = 5'd2; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (5) tick();
    bus.trig = 1'b1; td = cyc % 128;
    tick();
    bus.trig = 1'b0;
    collect(1'b0, DEPTH);
    n_checks++; if (got_n !== DEPTH || last_idx !== DEPTH - 1) begin n_fail++; $display("FAIL abortpost_count: got %0d last %0d expected %0d %0d", got_n, last_idx, DEPTH, DEPTH - 1); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (got[i] !== exp_s(td, 2, i)) begin n_fail++; $display("FAIL abortpost_sample[%0d]: got %0d expected %0d", i, got[i], exp_s(td, 2, i)); end
    end
  endtask

  task automatic test_abort_read();
    int td;
    bus.pretrig = 5'd3; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (3) tick();
    bus.trig = 1'b1; td = cyc % 128;
    tick();
    bus.trig = 1'b0;
    collect(1'b0, 7);
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_s(td, 3, 7)) begin n_fail++; $display("FAIL abortread_sample7: rd_valid %0b data %0d expected 1 %0d", bus.rd_valid, bus.rd_data, exp_s(td, 3, 7)); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.triggered !== 1'b0) begin n_fail++; $display("FAIL abortread_idle: busy %0b rd_valid %0b triggered %0b expected 0 0 0", bus.busy, bus.rd_valid, bus.triggered); end
    n_checks++; if (bus.rd_data !== 8'sd0 || bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL abortread_outputs: rd_data %0d rd_last %0b expected 0 0", bus.rd_data, bus.rd_last); end
  endtask

  task automatic test_reset_read();
    bus.pretrig = 5'd1; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    tick();
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    collect(1'b0, 3);
    n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL resetread_pre: rd_valid %0b expected 1", bus.rd_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.triggered !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.rd_data !== 8'sd0) begin
      n_fail++;
      $display("FAIL resetread_async: busy %0b triggered %0b rd_valid %0b rd_last %0b rd_data %0d expected all 0", bus.busy, bus.triggered, bus.rd_valid, bus.rd_last, bus.rd_data);
    end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.trig = 1'b0;
    bus.pretrig = '0; bus.rd_ready = 1'b1; bus.data = '0;
    test_reset();
    test_basic();
    test_pre_zero();
    test_clamp();
    test_trig_ignored();
    test_stall();
    test_abort_post();
    test_abort_read();
    test_pre_zero();
    test_reset_read();
    test_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
